bcd_step_counter: RTL and testbench

BCD_STEP_COUNTER -- requirements
Module: bcd_step_counter

---
 rtl/bcd_step_counter_if.sv | 22 ++
 rtl/bcd_step_counter.sv | 74 +++++++
 tb/tb_bcd_step_counter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_step_counter_if.sv
// rtl/bcd_step_counter_if.sv - control and digit-output bundle for bcd_step_counter
interface bcd_step_counter_if;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_err;
  logic [3:0] bcd;
  logic       step;
  logic       carry;
  logic       err;

  modport master (
    output en, up, load, load_val, clr_err,
    input  bcd, step, carry, err
  );

  modport slave (
    input  en, up, load, load_val, clr_err,
    output bcd, step, carry, err
  );
endinterface

// File: rtl/bcd_step_counter.sv
// rtl/bcd_step_counter.sv - prescaled up/down BCD digit counter with load and sticky load error
module bcd_step_counter #(
  parameter int TICK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_step_counter_if.slave  bus
);

  localparam logic [3:0] PCNT_LAST = 4'(TICK_DIV - 1);

  logic [3:0] pcnt;
  logic [3:0] bcd_q;
  logic       step_q;
  logic       carry_q;
  logic       err_q;
  logic       load_legal;

  assign load_legal = (bus.load_val <= 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= 4'd0;
      bcd_q   <= 4'd0;
      step_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      carry_q <= 1'b0;

      // An illegal load in the same cycle as clr_err must leave err set,
      // so the set is written after the clear.
      if (bus.clr_err)
        err_q <= 1'b0;
      if (bus.load && !load_legal)
        err_q <= 1'b1;

      if (bus.load) begin
        pcnt <= 4'd0;
        if (load_legal)
          bcd_q <= bus.load_val;
      end else if (bus.en) begin
        if (pcnt == PCNT_LAST) begin
          pcnt   <= 4'd0;
          step_q <= 1'b1;
          if (bus.up) begin
            if (bcd_q >= 4'd9) begin
              bcd_q   <= 4'd0;
              carry_q <= 1'b1;
            end else begin
              bcd_q <= bcd_q + 4'd1;
            end
          end else begin
            if (bcd_q == 4'd0) begin
              bcd_q   <= 4'd9;
              carry_q <= 1'b1;
            end else begin
              bcd_q <= bcd_q - 4'd1;
            end
          end
        end else begin
          pcnt <= pcnt + 4'd1;
        end
      end
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.step  = step_q;
  assign bus.carry = carry_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb/tb_bcd_step_counter.sv - directed and random bench for bcd_step_counter at TICK_DIV 4 and 1
module tb_bcd_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_err;

  int errors = 0;
  int checks = 0;
  int steps4;
  int carries4;

  int tdiv[2] = '{4, 1};
  int m_bcd[2];
  int m_cnt[2];
  int m_err[2];
  int m_step[2];
  int m_carry[2];

  always #5 clk = ~clk;

  bcd_step_counter_if bus4 ();
  bcd_step_counter_if bus1 ();

  assign bus4.en = en;
  assign bus4.up = up;
  assign bus4.load = load;
  assign bus4.load_val = load_val;
  assign bus4.clr_err = clr_err;
  assign bus1.en = en;
  assign bus1.up = up;
  assign bus1.load = load;
  assign bus1.load_val = load_val;
  assign bus1.clr_err = clr_err;

  bcd_step_counter #(.TICK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  bcd_step_counter #(.TICK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a digit mod 10 advanced once per tdiv enabled cycles.
  task automatic model_update(input int k);
    int nxt;
    if (rst) begin
      m_bcd[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_step[k] = 0; m_carry[k] = 0;
    end else begin
      m_step[k] = 0;
      m_carry[k] = 0;
      if (clr_err) m_err[k] = 0;
      if (load) begin
        m_cnt[k] = 0;
        if (int'(load_val) < 10) m_bcd[k] = int'(load_val);
        else m_err[k] = 1;
      end else if (en) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == tdiv[k]) begin
          m_cnt[k] = 0;
          m_step[k] = 1;
          nxt = up ? m_bcd[k] + 1 : m_bcd[k] - 1;
          m_carry[k] = (nxt < 0 || nxt > 9) ? 1 : 0;
          m_bcd[k] = (nxt + 10) % 10;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check("bcd_div4", 32'(bus4.bcd), m_bcd[0]);
    check("step_div4", 32'(bus4.step), m_step[0]);
    check("carry_div4", 32'(bus4.carry), m_carry[0]);
    check("err_div4", 32'(bus4.err), m_err[0]);
    check("range_div4", 32'(bus4.bcd <= 4'd9), 1);
    check("bcd_div1", 32'(bus1.bcd), m_bcd[1]);
    check("step_div1", 32'(bus1.step), m_step[1]);
    check("carry_div1", 32'(bus1.carry), m_carry[1]);
    check("err_div1", 32'(bus1.err), m_err[1]);
    check("range_div1", 32'(bus1.bcd <= 4'd9), 1);
    if (bus4.step === 1'b1) steps4++;
    if (bus4.carry === 1'b1) carries4++;
  endtask

  task automatic set_in(input logic r, input logic e, input logic u, input logic l,
                        input logic [3:0] lv, input logic c);
    rst = r; en = e; up = u; load = l; load_val = lv; clr_err = c;
  endtask

  initial begin
    // reset wins over load, en and clr_err
    set_in(1, 1, 1, 1, 4'd5, 1);
    tick(); tick();
    check("reset_bcd", 32'(bus4.bcd), 0);
    check("reset_err", 32'(bus4.err), 0);

    // 40 enabled cycles counting up from reset
    steps4 = 0; carries4 = 0;
    set_in(0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 40; i++) tick();
    check("up40_steps", steps4, 10);
    check("up40_carries", carries4, 1);
    check("up40_final_bcd", 32'(bus4.bcd), 0);

    // load 0 then count down: 9 with carry, then 8
    set_in(0, 0, 0, 1, 4'd0, 0); tick();
    set_in(0, 1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 8; i++) tick();
    check("down_bcd", 32'(bus4.bcd), 8);

    // illegal load keeps value and sets err; clr_err alone clears; both together sets
    set_in(0, 0, 1, 1, 4'd5, 0); tick();
    set_in(0, 0, 1, 1, 4'd12, 0); tick();
    check("illegal_bcd_held", 32'(bus4.bcd), 5);
    check("illegal_err_set", 32'(bus4.err), 1);
    set_in(0, 0, 1, 0, 4'd0, 1); tick();
    check("clr_err_alone", 32'(bus4.err), 0);
    set_in(0, 0, 1, 1, 4'd15, 1); tick();
    check("clr_and_illegal", 32'(bus4.err), 1);
    set_in(0, 0, 1, 0, 4'd0, 1); tick();

    // load collides with a due step: load wins, then full spacing to 8
    set_in(0, 1, 1, 1, 4'd2, 0); tick();
    set_in(0, 1, 1, 0, 4'd0, 0); tick(); tick(); tick();
    set_in(0, 1, 1, 1, 4'd7, 0); tick();
    check("load_over_step_bcd", 32'(bus4.bcd), 7);
    check("load_over_step_nostep", 32'(bus4.step), 0);
    set_in(0, 1, 1, 0, 4'd0, 0);
    tick(); tick(); tick(); tick();
    check("after_load_step_bcd", 32'(bus4.bcd), 8);

    // TICK_DIV=1 from 8: 9, 0 with carry, 1
    set_in(0, 0, 1, 1, 4'd8, 0); tick();
    set_in(0, 1, 1, 0, 4'd0, 0);
    tick(); check("div1_9", 32'(bus1.bcd), 9);
    tick(); check("div1_0", 32'(bus1.bcd), 0); check("div1_carry", 32'(bus1.carry), 1);
    tick(); check("div1_1", 32'(bus1.bcd), 1);

    // reset in the cycle a 9->0 step is due discards it
    set_in(0, 0, 1, 1, 4'd9, 1); tick();
    set_in(0, 1, 1, 0, 4'd0, 0); tick(); tick(); tick();
    set_in(1, 1, 1, 0, 4'd0, 0); tick();
    check("rst_on_step_step", 32'(bus4.step), 0);
    check("rst_on_step_carry", 32'(bus4.carry), 0);
    set_in(0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 6; i++) tick();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
             ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
